// File: rtl/credit_tx_bridge_pkg.sv
// Shared link configuration for the credit-flow input bridge lanes.
// Path width, valid-bit position and default credit depth of the fabric switch input.
package credit_tx_bridge_pkg;

    localparam int PATH_WIDTH   = 8;
    localparam int PATH_BITS    = PATH_WIDTH + 1;
    localparam int VALID_BIT    = PATH_WIDTH;
    localparam int LINK_CREDITS = 2;

endpackage

// File: rtl/credit_tx_fifo.sv
// Synchronous FIFO, power-of-two depth, extra pointer bit disambiguates full from empty.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; full_nxt reflects this cycle's update.
module credit_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full_nxt = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/credit_tx_bridge.sv
// Credit-flow transmitter lane: buffers host words and launches them into the fabric while credits remain.
// Latency: host accept to d_out valid is 2 cycles (write, launch); one word per cycle while credits last.
// Backpressure: s_ready registered, low when the FIFO fills or conf_en is high; optional stats under CREDIT_TX_STATS_EN.
module credit_tx_bridge
    import credit_tx_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int INIT_CREDITS = LINK_CREDITS,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conf_en,
    input  logic [PATH_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [PATH_BITS-1:0]  d_out,
    input  logic                  c_in,
    output logic [CNT_W-1:0]      credits,
    output logic                  err_credit
`ifdef CREDIT_TX_STATS_EN
    ,
    output logic [31:0]           tx_count,
    output logic [31:0]           stall_count
`endif
);

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(INIT_CREDITS);

    logic                  s_ready_q, s_ready_d;
    logic [PATH_BITS-1:0]  d_out_q, d_out_d;
    logic [CNT_W-1:0]      credits_q, credits_d;
    logic                  err_q, err_d;

    logic                  push;
    logic                  launch;
    logic                  fifo_empty;
    logic                  fifo_full_nxt;
    logic [PATH_WIDTH-1:0] head_dat;

    assign push   = s_valid && s_ready_q;
    assign launch = !fifo_empty && (credits_q != '0) && !conf_en;

    credit_tx_fifo #(
        .WIDTH (PATH_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (s_data),
        .pop      (launch),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    always_comb begin
        s_ready_d = !fifo_full_nxt && !conf_en;
        d_out_d   = '0;
        credits_d = credits_q;
        err_d     = err_q;
        if (launch) begin
            d_out_d = {1'b1, head_dat};
        end
        // A return in the launch cycle cancels the spend, so it can never overflow.
        if (launch && !c_in) begin
            credits_d = credits_q - 1'b1;
        end else if (!launch && c_in) begin
            if (credits_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready_q <= 1'b0;
            d_out_q   <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            s_ready_q <= s_ready_d;
            d_out_q   <= d_out_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign d_out      = d_out_q;
    assign credits    = credits_q;
    assign err_credit = err_q;

`ifdef CREDIT_TX_STATS_EN
    logic [31:0] tx_count_q, tx_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        stall;

    assign stall = !fifo_empty && (credits_q == '0) && !conf_en;

    always_comb begin
        tx_count_d    = tx_count_q + {31'd0, launch};
        stall_count_d = stall_count_q + {31'd0, stall};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            tx_count_q    <= tx_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign tx_count    = tx_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_credit_tx_bridge.sv
// Randomized and directed bench for credit_tx_bridge against a queue-based reference model.
module tb_credit_tx_bridge;
    import credit_tx_bridge_pkg::*;

    localparam int DEPTH = 4;
    localparam int INIT  = 2;
    localparam int CW    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  conf_en;
    logic [PATH_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [PATH_BITS-1:0]  d_out;
    logic                  c_in;
    logic [CW-1:0]         credits;
    logic                  err_credit;
`ifdef CREDIT_TX_STATS_EN
    logic [31:0]           tx_count;
    logic [31:0]           stall_count;
`endif

    credit_tx_bridge #(
        .FIFO_DEPTH   (DEPTH),
        .INIT_CREDITS (INIT),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .conf_en    (conf_en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .d_out      (d_out),
        .c_in       (c_in),
        .credits    (credits),
        .err_credit (err_credit)
`ifdef CREDIT_TX_STATS_EN
        ,
        .tx_count    (tx_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    // Reference model: the FIFO as a queue of words plus a credit integer.
    logic [PATH_WIDTH-1:0] mq[$];
    int                    m_cred;
    logic                  m_err;
    logic                  m_sready;
    logic [PATH_BITS-1:0]  m_dout;
    logic                  m_pushed;
    logic [31:0]           m_tx;
    logic [31:0]           m_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic [PATH_WIDTH-1:0] d,
                              input logic c, input logic cf);
        int   had;
        logic lch;
        had = mq.size();
        lch = (had > 0) && (m_cred > 0) && !cf;
        if (had > 0 && m_cred == 0 && !cf) m_stall = m_stall + 1;
        if (lch) begin
            m_dout = {1'b1, mq.pop_front()};
            m_tx   = m_tx + 1;
        end else begin
            m_dout = '0;
        end
        m_pushed = v && m_sready;
        if (m_pushed) mq.push_back(d);
        if (lch && !c) begin
            m_cred--;
        end else if (!lch && c) begin
            if (m_cred == INIT) m_err = 1'b1;
            else m_cred++;
        end
        m_sready = (mq.size() < DEPTH) && !cf;
    endtask

    task automatic cycle(input logic v, input logic [PATH_WIDTH-1:0] d,
                         input logic c, input logic cf);
        s_valid = v;
        s_data  = d;
        c_in    = c;
        conf_en = cf;
        @(posedge clk);
        model_step(v, d, c, cf);
        @(negedge clk);
        check_eq("d_out", 32'(d_out), 32'(m_dout));
        check_eq("s_ready", 32'(s_ready), 32'(m_sready));
        check_eq("credits", 32'(credits), 32'(m_cred));
        check_eq("err_credit", 32'(err_credit), 32'(m_err));
`ifdef CREDIT_TX_STATS_EN
        check_eq("tx_count", tx_count, m_tx);
        check_eq("stall_count", stall_count, m_stall);
`endif
        if (d_out[VALID_BIT]) n_out++;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        c_in    = 1'b0;
        conf_en = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_d_out", 32'(d_out), 32'd0);
            check_eq("rst_s_ready", 32'(s_ready), 32'd0);
            check_eq("rst_credits", 32'(credits), INIT);
            check_eq("rst_err", 32'(err_credit), 32'd0);
        end
        rst = 1'b1;
        mq.delete();
        m_cred   = INIT;
        m_err    = 1'b0;
        m_sready = 1'b0;
        m_dout   = '0;
        m_tx     = '0;
        m_stall  = '0;
    endtask

    // Return outstanding credits until the lane is idle with a full credit count.
    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (mq.size() == 0 && m_cred == INIT) break;
            cycle(1'b0, '0, (m_cred < INIT), 1'b0);
        end
        check_eq("drain_done", 32'(mq.size() == 0 && m_cred == INIT), 32'd1);
    endtask

    initial begin
        int          base;
        int          pushed;
        logic [31:0] tx_snap;

        do_reset();

        // Idle after reset
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("idle_ready", 32'(s_ready), 32'd1);
        check_eq("idle_credits", 32'(credits), 32'd2);

        // Credit exhaustion
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        check_eq("exh_w0", 32'(d_out), 32'h111);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("exh_w1", 32'(d_out), 32'h122);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("exh_gap", 32'(d_out), 32'd0);
        check_eq("exh_cred", 32'(credits), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("exh_ret_nolaunch", 32'(d_out), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("exh_w2", 32'(d_out), 32'h133);
        check_eq("exh_cred_after", 32'(credits), 32'd0);

        // Launch and credit return in the same cycle
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("sim_word", 32'(d_out), 32'h1A5);
        check_eq("sim_cred", 32'(credits), 32'd1);
        check_eq("sim_err", 32'(err_credit), 32'd0);
        drain();

        // FIFO full and pointer wrap
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        check_eq("full_ready", 32'(s_ready), 32'd0);
        base   = n_out;
        pushed = 4;
        for (int i = 0; i < 80; i++) begin
            if (n_out - base >= 8) break;
            cycle(pushed < 8, 8'h40 + 8'(pushed), (m_cred < INIT) && ($urandom_range(1) == 1), 1'b0);
            if (m_pushed) pushed++;
        end
        check_eq("wrap_words", n_out - base, 8);
        drain();

        // conf_en pause with two queued words
        cycle(1'b1, 8'hB1, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 8'hDD, 1'b1, 1'b1);
        cycle(1'b1, 8'hDD, 1'b1, 1'b1);
        cycle(1'b1, 8'hDD, 1'b0, 1'b1);
        check_eq("conf_ready", 32'(s_ready), 32'd0);
        check_eq("conf_dout", 32'(d_out), 32'd0);
        check_eq("conf_cred", 32'(credits), 32'd2);
        tx_snap = m_tx;
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("conf_w0", 32'(d_out), 32'h1C1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("conf_w1", 32'(d_out), 32'h1C2);
`ifdef CREDIT_TX_STATS_EN
        check_eq("conf_tx_delta", tx_count, tx_snap + 32'd2);
`else
        check_eq("conf_tx_model", m_tx - tx_snap, 32'd2);
`endif
        drain();

        // Randomized traffic with legal credit returns
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(1) == 1, 8'($urandom),
                  (m_cred < INIT) && ($urandom_range(2) == 0),
                  $urandom_range(7) == 0);
        end
        drain();

        // Credit overflow is sticky until reset
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("ovf_err", 32'(err_credit), 32'd1);
        check_eq("ovf_cred", 32'(credits), 32'd2);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check_eq("ovf_sticky", 32'(err_credit), 32'd1);
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("ovf_cleared", 32'(err_credit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
